// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_evt_if.sv
// Request/status bundle for the OR-reduction event aggregator.
// The master drives requests, mask, mode and clears; the slave returns status and flags.
interface gf180mcu_fd_sc_mcu7t5v0__orn_evt_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] MASK;
  logic             MODE;
  logic [WIDTH-1:0] CLR;
  logic [WIDTH-1:0] STAT;
  logic             Z;
  logic             ZRISE;

  modport master (
    output A,
    output MASK,
    output MODE,
    output CLR,
    input  STAT,
    input  Z,
    input  ZRISE
  );

  modport slave (
    input  A,
    input  MASK,
    input  MODE,
    input  CLR,
    output STAT,
    output Z,
    output ZRISE
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_evt.sv
// Registered N-input OR aggregator: masked level/sticky capture, then a pipelined
// GROUP-ary OR tree whose last register is Z, plus a one-cycle rising-edge flag.
module gf180mcu_fd_sc_mcu7t5v0__orn_evt #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input logic CLK,
  input logic RN,
  gf180mcu_fd_sc_mcu7t5v0__orn_evt_if.slave bus
);

  function automatic int lvl_w(input int l);
    int w;
    w = WIDTH;
    for (int i = 0; i < l; i++) begin
      w = (w + GROUP - 1) / GROUP;
    end
    return w;
  endfunction

  function automatic int tree_depth();
    int w;
    int d;
    w = WIDTH;
    d = 0;
    while (w > 1) begin
      w = (w + GROUP - 1) / GROUP;
      d++;
    end
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) begin
      o += lvl_w(i);
    end
    return o;
  endfunction

  localparam int S      = tree_depth();
  localparam int NODES  = lvl_off(S + 1);
  localparam int TREE_W = NODES - WIDTH;
  // Levels 0..S-1 feed the next level; the top node (Z) feeds nothing.
  localparam int FEED_W = NODES - 1;

  logic [WIDTH-1:0]  stat_q, stat_d;
  logic [TREE_W-1:0] tree_q, tree_d;
  logic              zrise_q, zrise_d;
  logic [FEED_W-1:0] node_vec;
  logic              z_q, z_d;

  // Set term ORed last so a same-cycle clear can never drop a new event.
  always_comb begin
    stat_d = bus.A & bus.MASK;
    if (bus.MODE) begin
      stat_d = (stat_q & ~bus.CLR) | (bus.A & bus.MASK);
    end
  end

  always_comb begin
    node_vec = '0;
    node_vec[WIDTH-1:0] = stat_q;
    for (int i = 0; i < TREE_W - 1; i++) begin
      node_vec[WIDTH+i] = tree_q[i];
    end
  end

  genvar gi, gj;
  generate
    for (gi = 1; gi <= S; gi++) begin : g_lvl
      localparam int PW      = lvl_w(gi - 1);
      localparam int LW      = lvl_w(gi);
      localparam int IN_OFF  = lvl_off(gi - 1);
      localparam int OUT_OFF = lvl_off(gi) - WIDTH;
      for (gj = 0; gj < LW; gj++) begin : g_node
        localparam int BASE = gj * GROUP;
        // A trailing partial group ORs only the bits that exist.
        localparam int CNT  = ((PW - BASE) < GROUP) ? (PW - BASE) : GROUP;
        assign tree_d[OUT_OFF+gj] = |node_vec[IN_OFF+BASE +: CNT];
      end
    end
  endgenerate

  assign z_q = tree_q[TREE_W-1];
  assign z_d = tree_d[TREE_W-1];

  always_comb begin
    zrise_d = z_d & ~z_q;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      stat_q  <= '0;
      tree_q  <= '0;
      zrise_q <= 1'b0;
    end else begin
      stat_q  <= stat_d;
      tree_q  <= tree_d;
      zrise_q <= zrise_d;
    end
  end

  assign bus.STAT  = stat_q;
  assign bus.Z     = z_q;
  assign bus.ZRISE = zrise_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__orn_evt.sv
// Directed bench for the OR aggregator: default 8/4 instance plus 5/2 and 64/8 sweeps.
// Outputs are sampled 1 time unit after each rising edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__orn_evt;

  logic clk = 1'b0;
  logic rn;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__orn_evt_if #(.WIDTH(8))  if8 ();
  gf180mcu_fd_sc_mcu7t5v0__orn_evt_if #(.WIDTH(5))  if5 ();
  gf180mcu_fd_sc_mcu7t5v0__orn_evt_if #(.WIDTH(64)) if64 ();

  gf180mcu_fd_sc_mcu7t5v0__orn_evt #(.WIDTH(8), .GROUP(4)) u8 (
    .CLK(clk), .RN(rn), .bus(if8)
  );
  gf180mcu_fd_sc_mcu7t5v0__orn_evt #(.WIDTH(5), .GROUP(2)) u5 (
    .CLK(clk), .RN(rn), .bus(if5)
  );
  gf180mcu_fd_sc_mcu7t5v0__orn_evt #(.WIDTH(64), .GROUP(8)) u64 (
    .CLK(clk), .RN(rn), .bus(if64)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] es, input logic ez, input logic ezr);
    chk({tag, ".STAT"},  64'(if8.STAT),  64'(es));
    chk({tag, ".Z"},     64'(if8.Z),     64'(ez));
    chk({tag, ".ZRISE"}, 64'(if8.ZRISE), 64'(ezr));
  endtask

  initial begin
    logic [4:0]  b5;
    logic [63:0] b64;

    rn = 1'b0;
    if8.A = '0;  if8.MASK = '0;  if8.MODE = 1'b0;  if8.CLR = '0;
    if5.A = '0;  if5.MASK = '0;  if5.MODE = 1'b0;  if5.CLR = '0;
    if64.A = '0; if64.MASK = '0; if64.MODE = 1'b0; if64.CLR = '0;
    #2;
    chk8("rst0", 8'h00, 1'b0, 1'b0);
    chk("rst0.u5.STAT", 64'(if5.STAT), 64'h0);
    chk("rst0.u5.Z", 64'(if5.Z), 64'h0);
    chk("rst0.u64.STAT", if64.STAT, 64'h0);
    chk("rst0.u64.Z", 64'(if64.Z), 64'h0);

    // Reset held with all requests high, then released
    if8.A = 8'hFF; if8.MASK = 8'hFF;
    tick(2);
    chk8("rst_hold", 8'h00, 1'b0, 1'b0);
    rn = 1'b1;
    tick(1); chk8("rel_e1", 8'hFF, 1'b0, 1'b0);
    tick(1); chk8("rel_e2", 8'hFF, 1'b0, 1'b0);
    tick(1); chk8("rel_e3", 8'hFF, 1'b1, 1'b1);
    tick(1); chk8("rel_e4", 8'hFF, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge
    #2 rn = 1'b0;
    #1 chk8("async_rst", 8'h00, 1'b0, 1'b0);
    tick(1); chk8("rst_hold2", 8'h00, 1'b0, 1'b0);
    rn = 1'b1;
    tick(1); chk8("rel2_e1", 8'hFF, 1'b0, 1'b0);
    tick(1); chk8("rel2_e2", 8'hFF, 1'b0, 1'b0);
    tick(1); chk8("rel2_e3", 8'hFF, 1'b1, 1'b1);
    tick(1); chk8("rel2_e4", 8'hFF, 1'b1, 1'b0);

    // Level mode single-cycle pulse
    if8.A = 8'h00;
    tick(4); chk8("lvl_idle", 8'h00, 1'b0, 1'b0);
    if8.A = 8'h10;
    tick(1); chk8("lvl_k", 8'h10, 1'b0, 1'b0);
    if8.A = 8'h00;
    tick(1); chk8("lvl_k1", 8'h00, 1'b0, 1'b0);
    tick(1); chk8("lvl_k2", 8'h00, 1'b1, 1'b1);
    tick(1); chk8("lvl_k3", 8'h00, 1'b0, 1'b0);

    // Masking
    if8.A = 8'h0F; if8.MASK = 8'hF0;
    tick(1); chk8("mask_e1", 8'h00, 1'b0, 1'b0);
    tick(2); chk8("mask_e3", 8'h00, 1'b0, 1'b0);
    if8.MASK = 8'hFF;
    tick(1); chk8("unmask_e1", 8'h0F, 1'b0, 1'b0);
    tick(1); chk8("unmask_e2", 8'h0F, 1'b0, 1'b0);
    tick(1); chk8("unmask_e3", 8'h0F, 1'b1, 1'b1);
    tick(1); chk8("unmask_e4", 8'h0F, 1'b1, 1'b0);

    // Sticky capture and set/clear race
    if8.A = 8'h00;
    tick(3); chk8("stk_idle", 8'h00, 1'b0, 1'b0);
    if8.MODE = 1'b1; if8.A = 8'h01;
    tick(1); chk8("stk_set", 8'h01, 1'b0, 1'b0);
    if8.A = 8'h00;
    tick(1); chk8("stk_hold1", 8'h01, 1'b0, 1'b0);
    tick(1); chk8("stk_hold2", 8'h01, 1'b1, 1'b1);
    tick(1); chk8("stk_hold3", 8'h01, 1'b1, 1'b0);
    if8.CLR = 8'h01; if8.A = 8'h01;
    tick(1); chk8("stk_race", 8'h01, 1'b1, 1'b0);
    if8.A = 8'h00;
    tick(1); chk8("stk_clr", 8'h00, 1'b1, 1'b0);
    tick(1); chk8("stk_clr1", 8'h00, 1'b1, 1'b0);
    tick(1); chk8("stk_clr2", 8'h00, 1'b0, 1'b0);
    if8.CLR = 8'h00;

    // Masking a set sticky bit does not clear it
    if8.A = 8'h01;
    tick(1); chk("stk_mask_set.STAT", 64'(if8.STAT), 64'h01);
    if8.MASK = 8'hFE; if8.A = 8'h00;
    tick(1); chk("stk_mask_keep.STAT", 64'(if8.STAT), 64'h01);

    // Mode switches
    if8.MASK = 8'hFF; if8.A = 8'h81;
    tick(1); chk("mode_s81.STAT", 64'(if8.STAT), 64'h81);
    if8.A = 8'h00;
    tick(1); chk("mode_h81.STAT", 64'(if8.STAT), 64'h81);
    if8.MODE = 1'b0;
    tick(1); chk("mode_to0.STAT", 64'(if8.STAT), 64'h00);
    if8.MODE = 1'b1; if8.A = 8'h02;
    tick(1); chk("mode_to1.STAT", 64'(if8.STAT), 64'h02);
    if8.MODE = 1'b0; if8.A = 8'h04;
    tick(1); chk("mode_lvl04.STAT", 64'(if8.STAT), 64'h04);
    if8.MODE = 1'b1; if8.A = 8'h00;
    tick(1); chk("mode_keep04.STAT", 64'(if8.STAT), 64'h04);
    if8.CLR = 8'hFF;
    tick(1); chk("mode_clrall.STAT", 64'(if8.STAT), 64'h00);
    if8.CLR = 8'h00; if8.MODE = 1'b0;

    // WIDTH=5 GROUP=2: depth 3, A->Z latency 4
    for (int i = 0; i < 5; i++) begin
      for (int m = 0; m < 2; m++) begin
        b5 = 5'(1) << i;
        if5.MASK = (m == 0) ? 5'h1F : ~b5;
        if5.A = b5;
        tick(1); chk($sformatf("w5_b%0d_m%0d.STAT", i, m), 64'(if5.STAT), (m == 0) ? 64'(b5) : 64'h0);
        if5.A = '0;
        tick(2); chk($sformatf("w5_b%0d_m%0d.Zearly", i, m), 64'(if5.Z), 64'h0);
        tick(1);
        chk($sformatf("w5_b%0d_m%0d.Z", i, m), 64'(if5.Z), (m == 0) ? 64'h1 : 64'h0);
        chk($sformatf("w5_b%0d_m%0d.ZRISE", i, m), 64'(if5.ZRISE), (m == 0) ? 64'h1 : 64'h0);
        tick(1);
        chk($sformatf("w5_b%0d_m%0d.Zend", i, m), 64'(if5.Z), 64'h0);
        chk($sformatf("w5_b%0d_m%0d.ZRend", i, m), 64'(if5.ZRISE), 64'h0);
      end
    end

    // WIDTH=64 GROUP=8: depth 2, A->Z latency 3
    for (int i = 0; i < 64; i++) begin
      for (int m = 0; m < 2; m++) begin
        b64 = 64'(1) << i;
        if64.MASK = (m == 0) ? {64{1'b1}} : ~b64;
        if64.A = b64;
        tick(1); chk($sformatf("w64_b%0d_m%0d.STAT", i, m), if64.STAT, (m == 0) ? b64 : 64'h0);
        if64.A = '0;
        tick(1); chk($sformatf("w64_b%0d_m%0d.Zearly", i, m), 64'(if64.Z), 64'h0);
        tick(1);
        chk($sformatf("w64_b%0d_m%0d.Z", i, m), 64'(if64.Z), (m == 0) ? 64'h1 : 64'h0);
        chk($sformatf("w64_b%0d_m%0d.ZRISE", i, m), 64'(if64.ZRISE), (m == 0) ? 64'h1 : 64'h0);
        tick(1);
        chk($sformatf("w64_b%0d_m%0d.Zend", i, m), 64'(if64.Z), 64'h0);
        chk($sformatf("w64_b%0d_m%0d.ZRend", i, m), 64'(if64.ZRISE), 64'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
